// File: rtl/onchip_memory_pipelined.sv
// onchip_memory_pipelined: Avalon-MM pipelined slave RAM with hardware zero-fill
// Ports:
//   clk_i, reset_i (async, active-high)
//   chipselect_i, address_i, byteenable_i, read_i, write_i, writedata_i, clken_i : request side
//   readdata_o, readdatavalid_o : read response, READ_LATENCY cycles after acceptance
//   waitrequest_o : high during zero-fill or while clken_i is low
//   init_done_o   : high once zero-fill has completed
//   parity_error_o: byte parity mismatch on returned data (ONCHIP_MEM_PARITY_EN), else 0
// Optional feature macro: ONCHIP_MEM_PARITY_EN
module onchip_memory_pipelined #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 13,
    parameter int READ_LATENCY = 1,
    parameter int ZERO_INIT    = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    chipselect_i,
    input  logic [ADDR_WIDTH-1:0]   address_i,
    input  logic [DATA_WIDTH/8-1:0] byteenable_i,
    input  logic                    read_i,
    input  logic                    write_i,
    input  logic [DATA_WIDTH-1:0]   writedata_i,
    input  logic                    clken_i,
    output logic [DATA_WIDTH-1:0]   readdata_o,
    output logic                    readdatavalid_o,
    output logic                    waitrequest_o,
    output logic                    init_done_o,
    output logic                    parity_error_o
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef ONCHIP_MEM_PARITY_EN
    localparam int MW = DATA_WIDTH + NB;
`else
    localparam int MW = DATA_WIDTH;
`endif
    typedef enum logic {INIT, READY} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fill_q, fill_d;
    logic [MW-1:0]         mem_q [DEPTH];
    logic [MW-1:0]         rd1_q, rd2_q, out_word;
    logic                  v1_q, v2_q;
    logic                  accept, rd_acc, wr_acc;

    always_comb begin
        waitrequest_o = (state_q == INIT) | ~clken_i;
        accept        = chipselect_i & (read_i | write_i) & ~waitrequest_o;
        wr_acc        = accept & write_i;
        rd_acc        = accept & read_i & ~write_i;
        state_d       = state_q;
        fill_d        = fill_q;
        if (state_q == INIT) begin
            fill_d = fill_q + 1'b1;
            if (&fill_q) state_d = READY;
        end
    end

    // Zero-fill ignores clken; zero bytes already carry correct even parity.
    always_ff @(posedge clk_i) begin
        if (state_q == INIT) mem_q[fill_q] <= '0;
        else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (byteenable_i[i]) begin
                    mem_q[address_i][8*i +: 8] <= writedata_i[8*i +: 8];
`ifdef ONCHIP_MEM_PARITY_EN
                    mem_q[address_i][DATA_WIDTH+i] <= ^writedata_i[8*i +: 8];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= (ZERO_INIT != 0) ? INIT : READY;
            fill_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            if (clken_i) begin
                v1_q <= rd_acc;
                v2_q <= v1_q;
                if (rd_acc) rd1_q <= mem_q[address_i];
                if (v1_q) rd2_q <= rd1_q;
            end
        end
    end

    always_comb begin
        out_word        = (READ_LATENCY == 2) ? rd2_q : rd1_q;
        readdatavalid_o = (READ_LATENCY == 2) ? v2_q : v1_q;
        readdata_o      = out_word[DATA_WIDTH-1:0];
        init_done_o     = (state_q == READY);
        parity_error_o  = 1'b0;
`ifdef ONCHIP_MEM_PARITY_EN
        for (int i = 0; i < NB; i++)
            parity_error_o = parity_error_o | (out_word[DATA_WIDTH+i] ^ (^out_word[8*i +: 8]));
        parity_error_o = parity_error_o & readdatavalid_o;
`endif
    end
endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// tb_onchip_memory_pipelined: directed plus random checks of two latency variants against a reference model
module tb_onchip_memory_pipelined;
    logic        clk = 1'b0;
    logic        reset, cs, rd, wr, clken;
    logic [3:0]  addr, be;
    logic [31:0] wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        rdv_a, rdv_b, wait_a, wait_b, done_a, done_b, perr_a, perr_b;

    always #5 clk = ~clk;

    onchip_memory_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .ZERO_INIT(1)) u_l1 (
        .clk_i(clk), .reset_i(reset), .chipselect_i(cs), .address_i(addr), .byteenable_i(be),
        .read_i(rd), .write_i(wr), .writedata_i(wdata), .clken_i(clken),
        .readdata_o(rdata_a), .readdatavalid_o(rdv_a), .waitrequest_o(wait_a),
        .init_done_o(done_a), .parity_error_o(perr_a));

    onchip_memory_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .ZERO_INIT(1)) u_l2 (
        .clk_i(clk), .reset_i(reset), .chipselect_i(cs), .address_i(addr), .byteenable_i(be),
        .read_i(rd), .write_i(wr), .writedata_i(wdata), .clken_i(clken),
        .readdata_o(rdata_b), .readdatavalid_o(rdv_b), .waitrequest_o(wait_b),
        .init_done_o(done_b), .parity_error_o(perr_b));

    // Reference model: word array, fill-edge count, and expected responses keyed by
    // the number of clken=1 edges since reset at which each response must be visible.
    logic [31:0] mem_m [16];
    bit          bad_m [16];
    int          fill_cnt, tick, n_cmp, n_err;
    bit          ready_m;
    logic [32:0] exp1 [int];
    logic [32:0] exp2 [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] w;
        w = {31'b0, !ready_m || !clken};
        check("wait_l1", {31'b0, wait_a}, w);
        check("wait_l2", {31'b0, wait_b}, w);
        check("done_l1", {31'b0, done_a}, {31'b0, ready_m});
        check("done_l2", {31'b0, done_b}, {31'b0, ready_m});
        check("rdv_l1", {31'b0, rdv_a}, {31'b0, exp1.exists(tick)});
        check("rdv_l2", {31'b0, rdv_b}, {31'b0, exp2.exists(tick)});
        if (exp1.exists(tick)) begin
            check("rdata_l1", rdata_a, exp1[tick][31:0]);
            check("perr_l1", {31'b0, perr_a}, {31'b0, exp1[tick][32]});
        end else check("perr_l1_idle", {31'b0, perr_a}, 32'h0);
        if (exp2.exists(tick)) begin
            check("rdata_l2", rdata_b, exp2[tick][31:0]);
            check("perr_l2", {31'b0, perr_b}, {31'b0, exp2[tick][32]});
        end else check("perr_l2_idle", {31'b0, perr_b}, 32'h0);
    endtask

    task automatic cycle();
        bit acc;
        acc = cs && (rd || wr) && ready_m && clken;
        @(posedge clk);
        if (!ready_m) fill_cnt++;
        if (acc && wr) begin
            for (int b = 0; b < 4; b++) if (be[b]) mem_m[addr][8*b +: 8] = wdata[8*b +: 8];
            if (be[1]) bad_m[addr] = 1'b0;
        end else if (acc && rd) begin
            exp1[tick+1] = {bad_m[addr], mem_m[addr]};
            exp2[tick+2] = {bad_m[addr], mem_m[addr]};
        end
        if (clken) tick++;
        ready_m = fill_cnt >= 16;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        check("rst_rdv_l1", {31'b0, rdv_a}, 32'h0);
        check("rst_rdv_l2", {31'b0, rdv_b}, 32'h0);
        check("rst_wait", {31'b0, wait_a}, 32'h1);
        check("rst_done", {31'b0, done_b}, 32'h0);
        check("rst_rdata", rdata_b, 32'h0);
        for (int i = 0; i < 16; i++) begin
            mem_m[i] = '0;
            bad_m[i] = 1'b0;
        end
        exp1.delete();
        exp2.delete();
        fill_cnt = 0;
        tick     = 0;
        ready_m  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle();
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        cycle();
    endtask

    task automatic wr_req(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        cs = 1'b1; rd = 1'b0; wr = 1'b1; addr = a; wdata = d; be = b;
        cycle();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_req(input logic [3:0] a);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a; be = $urandom_range(0, 15);
        cycle();
        cs = 1'b0; rd = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; clken = 1'b1;
        addr = '0; be = '0; wdata = '0;
        n_cmp = 0; n_err = 0;
        do_reset();
        for (int i = 0; i < 15; i++) cycle();
        check("fill_15_done", {31'b0, done_a}, 32'h0);
        cycle();
        check("fill_16_done", {31'b0, done_a}, 32'h1);
        check("fill_16_wait", {31'b0, wait_b}, 32'h0);
        for (int a = 0; a < 16; a++) begin
            cs = 1'b1; rd = 1'b1; addr = 4'(a);
            cycle();
        end
        idle(); idle();

        wr_req(4'd3, 32'hAABBCCDD, 4'hF);
        wr_req(4'd3, 32'h11223344, 4'h5);
        rd_req(4'd3);
        check("be_rdv_l1", {31'b0, rdv_a}, 32'h1);
        check("be_data_l1", rdata_a, 32'hAA22CC44);
        idle(); idle();

        for (int a = 0; a < 4; a++) wr_req(4'(a), 32'h10 + 32'(a), 4'hF);
        for (int a = 0; a < 4; a++) begin
            cs = 1'b1; rd = 1'b1; addr = 4'(a);
            cycle();
        end
        check("pipe_third", rdata_b, 32'h12);
        idle();
        check("pipe_fourth", rdata_b, 32'h13);
        idle(); idle();

        wr_req(4'd1, 32'h55, 4'hF);
        cs = 1'b1; rd = 1'b1; addr = 4'd1;
        cycle();
        clken = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("stall_wait", {31'b0, wait_b}, 32'h1);
        clken = 1'b1; cs = 1'b0; rd = 1'b0;
        cycle();
        check("stall_rdv_l2", {31'b0, rdv_b}, 32'h1);
        check("stall_data_l2", rdata_b, 32'h55);
        idle(); idle();

        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 4'd2; wdata = 32'h77; be = 4'hF;
        cycle();
        idle(); idle();
        rd_req(4'd2);
        check("rw_data_l1", rdata_a, 32'h77);
        idle(); idle();

        wr_req(4'd4, 32'hDEADBEEF, 4'hF);
        rd_req(4'd4);
        do_reset();
        for (int i = 0; i < 16; i++) cycle();
        rd_req(4'd4);
        check("rezero_l1", rdata_a, 32'h0);
        idle(); idle();

`ifdef ONCHIP_MEM_PARITY_EN
        wr_req(4'd5, 32'h12345678, 4'hF);
        u_l1.mem_q[5][9] = ~u_l1.mem_q[5][9];
        u_l2.mem_q[5][9] = ~u_l2.mem_q[5][9];
        mem_m[5][9] = ~mem_m[5][9];
        bad_m[5] = 1'b1;
        rd_req(4'd5);
        check("perr_hit_l1", {31'b0, perr_a}, 32'h1);
        idle();
        check("perr_hit_l2", {31'b0, perr_b}, 32'h1);
        rd_req(4'd6);
        idle();
        check("perr_clean_l2", {31'b0, perr_b}, 32'h0);
        idle();
`endif

        for (int i = 0; i < 400; i++) begin
            clken = ($urandom_range(0, 7) != 0);
            cs    = ($urandom_range(0, 3) != 0);
            rd    = 1'($urandom);
            wr    = ($urandom_range(0, 2) == 0);
            addr  = 4'($urandom);
            be    = 4'($urandom);
            wdata = $urandom;
            cycle();
        end
        clken = 1'b1;
        idle(); idle(); idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
